cla_pipe_addsub: RTL

Parametrised, pipelined carry-lookahead adder/subtractor: the next generation of the fixed 32-bit 4-bit-group CLA. Width, lookahead group size and pipeline depth are parameters. The block adds subtract mode, signed-overflow and zero flags, and a valid/ready handshake with full-throughput backpressure. It is intended as the datapath adder feeding registered ALU and accumulator stages.

---
 rtl/cla_pipe_addsub.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: parametrised, pipelined carry-lookahead adder/subtractor.
// Each of the STAGES register stages adds one SEG-bit slice. The carry is full
// lookahead inside a GROUP-bit group and ripples from group to group. A
// valid/ready chain gives full throughput and lets bubbles collapse.
module cla_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_c,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / GROUP;

  // Adds one SEG-bit slice and returns {carry_out, sum}. Each carry inside a
  // group is a sum of products of the group's g/p terms and the group
  // carry-in. The group carry-out feeds the next group.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic ci);
    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [SEG:0]   c;
    logic           term;
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = ci;
    for (int grp = 0; grp < NGRP; grp++) begin
      for (int i = 1; i <= GROUP; i++) begin
        term = c[grp*GROUP];
        for (int k = 0; k < i; k++) term = term & p[grp*GROUP+k];
        c[grp*GROUP+i] = term;
        for (int j = 0; j < i; j++) begin
          term = g[grp*GROUP+j];
          for (int k = j + 1; k < i; k++) term = term & p[grp*GROUP+k];
          c[grp*GROUP+i] = c[grp*GROUP+i] | term;
        end
      end
    end
    return {c[SEG], p ^ c[SEG-1:0]};
  endfunction

  // Subtraction is a + ~b + ~borrow_in, so only B and the carry-in are inverted.
  logic [WIDTH-1:0] b_eff;
  logic             c_in0;
  assign b_eff = sub ? ~b : b;
  assign c_in0 = sub ? ~cin : cin;

  // rdy[s] means stage s may load this edge. rdy[STAGES] is the downstream ready.
  logic [STAGES:0] rdy;
  assign rdy[STAGES] = i_ready;
  assign o_ready     = rdy[0];

  for (genvar s = 0; s < STAGES; s++) begin : stg
    localparam int LO = s * SEG;
    localparam int RW = WIDTH - LO;

    logic [RW-1:0]     src_a;
    logic [RW-1:0]     src_b;
    logic              src_c;
    logic              src_v;
    logic [SEG:0]      res;
    logic [LO+SEG-1:0] sum_d;
    logic [LO+SEG-1:0] sum_q;
    logic              c_q;
    logic              vld_q;

    if (s == 0) begin : src
      assign src_a = a;
      assign src_b = b_eff;
      assign src_c = c_in0;
      assign src_v = i_valid;
      assign sum_d = res[SEG-1:0];
    end else begin : src
      assign src_a = stg[s-1].keep.a_q;
      assign src_b = stg[s-1].keep.b_q;
      assign src_c = stg[s-1].c_q;
      assign src_v = stg[s-1].vld_q;
      assign sum_d = {res[SEG-1:0], stg[s-1].sum_q};
    end

    assign res    = seg_add(src_a[SEG-1:0], src_b[SEG-1:0], src_c);
    assign rdy[s] = !vld_q || rdy[s+1];

    // The valid bit follows upstream whenever this stage can load, so an empty stage refills even while later stages stall.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      vld_q <= 1'b0;
      else if (rdy[s]) vld_q <= src_v;
    end

    // The partial sum and carry load only with a real operation and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (rdy[s] && src_v) begin
        sum_q <= sum_d;
        c_q   <= res[SEG];
      end
    end

    if (s < STAGES - 1) begin : keep
      logic [RW-SEG-1:0] a_q;
      logic [RW-SEG-1:0] b_q;

      // Operand bits not yet added move down the pipe. Consumed bits are dropped here.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (rdy[s] && src_v) begin
          a_q <= src_a[RW-1:SEG];
          b_q <= src_b[RW-1:SEG];
        end
      end
    end

    if (s == STAGES - 1) begin : tail
      logic ovf_q;
      logic zero_q;

      // Flags are registered beside the final sum. The carry into the MSB is recovered as sum ^ a ^ b' at that bit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (rdy[s] && src_v) begin
          ovf_q  <= res[SEG] ^ res[SEG-1] ^ src_a[SEG-1] ^ src_b[SEG-1];
          zero_q <= (sum_d == '0);
        end
      end
    end
  end

  assign o_valid = stg[STAGES-1].vld_q;
  assign o_sum   = stg[STAGES-1].sum_q;
  assign o_c     = stg[STAGES-1].c_q;
  assign o_ovf   = stg[STAGES-1].tail.ovf_q;
  assign o_zero  = stg[STAGES-1].tail.zero_q;

endmodule
